// File: rtl/button_reader.sv
// Consumer end of the button-press FIFO: pops press codes into a hold register
// and exposes status, data and a saturating press count over a small MMIO window.
module button_reader #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic                  empty,
  input  logic                  mmio_rd,
  input  logic                  mmio_wr,
  input  logic [1:0]            mmio_addr,
  output logic [31:0]           mmio_rdata
);

  localparam int unsigned RDATA_WIDTH = 32;
  localparam logic [1:0]  ADDR_STATUS = 2'd0;
  localparam logic [1:0]  ADDR_DATA   = 2'd1;
  localparam logic [1:0]  ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [DATA_WIDTH-1:0]    hold_data;
  logic [COUNT_WIDTH-1:0]   count;
  logic                     hold_valid;
  logic                     data_rd;
  logic                     count_clr;
  logic                     capture;
  logic [RDATA_WIDTH-1:0]   rdata_next;

  // The hold register is valid exactly while the FSM sits in HOLD.
  assign hold_valid = (state == HOLD);
  assign data_rd    = mmio_rd && (mmio_addr == ADDR_DATA);
  assign count_clr  = mmio_wr && (mmio_addr == ADDR_COUNT);
  assign capture    = (state == WAIT);

  // Next-state and read-mux decode.
  always_comb begin
    state_next = state;
    rdata_next = '0;

    case (state)
      IDLE:    if (!empty) state_next = POP;
      POP:     state_next = WAIT;
      WAIT:    state_next = HOLD;
      HOLD:    if (data_rd) state_next = empty ? IDLE : POP;
      default: state_next = IDLE;
    endcase

    case (mmio_addr)
      ADDR_STATUS: rdata_next = RDATA_WIDTH'({~empty, hold_valid});
      ADDR_DATA:   rdata_next = hold_valid ? RDATA_WIDTH'(hold_data) : '0;
      ADDR_COUNT:  rdata_next = RDATA_WIDTH'(count);
      default:     rdata_next = '0;
    endcase
  end

  // rd_en is registered from the next state, so it is high exactly while state == POP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_en <= 1'b0;
    end else begin
      state <= state_next;
      rd_en <= (state_next == POP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
    end else if (capture) begin
      hold_data <= dout;
    end
  end

  // Saturating press counter; a clear coinciding with a capture leaves one press counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count_clr) begin
      count <= capture ? COUNT_WIDTH'(1) : '0;
    end else if (capture && (count != '1)) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_rdata <= '0;
    end else if (mmio_rd) begin
      mmio_rdata <= rdata_next;
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: a default instance fed by a queue-based FIFO model and
// a COUNT_WIDTH=2 instance fed by a free-running source for saturation and clear.
module tb_button_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en [2];
  logic        mmio_rd [2];
  logic        mmio_wr [2];
  logic [1:0]  mmio_addr [2];
  logic [31:0] mmio_rdata [2];

  logic [3:0]  dout0 = 4'h0;
  logic        empty0 = 1'b1;
  logic [3:0]  dout1 = 4'h0;
  logic        empty1 = 1'b1;

  logic        push_v = 1'b0;
  logic [3:0]  push_d = 4'h0;
  logic        gate = 1'b0;
  logic [3:0]  fq [$];
  int          pops0 = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_reader u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en[0]), .dout(dout0), .empty(empty0),
    .mmio_rd(mmio_rd[0]), .mmio_wr(mmio_wr[0]), .mmio_addr(mmio_addr[0]),
    .mmio_rdata(mmio_rdata[0])
  );

  button_reader #(.DATA_WIDTH(4), .COUNT_WIDTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en[1]), .dout(dout1), .empty(empty1),
    .mmio_rd(mmio_rd[1]), .mmio_wr(mmio_wr[1]), .mmio_addr(mmio_addr[1]),
    .mmio_rdata(mmio_rdata[1])
  );

  // Registered-read FIFO model; gate forces empty while a batch is being loaded.
  always @(posedge clk) begin
    if (rd_en[0]) begin
      pops0 <= pops0 + 1;
      if (fq.size() > 0) dout0 <= fq.pop_front();
    end
    if (push_v) fq.push_back(push_d);
    empty0 <= gate || (fq.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input int sel, input bit rd, input bit wr, input logic [1:0] addr,
                        output logic [31:0] data);
    @(negedge clk);
    mmio_rd[sel] = rd;
    mmio_wr[sel] = wr;
    mmio_addr[sel] = addr;
    @(negedge clk);
    mmio_rd[sel] = 1'b0;
    mmio_wr[sel] = 1'b0;
    data = mmio_rdata[sel];
  endtask

  task automatic push(input logic [3:0] code);
    @(negedge clk);
    push_v = 1'b1;
    push_d = code;
    @(negedge clk);
    push_v = 1'b0;
  endtask

  task automatic wait_rd_en(input int sel, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (rd_en[sel]) seen = 1'b1;
    end
  endtask

  // Poll status until a code is held; an expired poll counts as a failed check.
  task automatic wait_hold(input int sel, output logic [31:0] st);
    st = '0;
    for (int i = 0; i < 20 && !st[0]; i++) access(sel, 1'b1, 1'b0, 2'd0, st);
    check("hold_wait", 32'(st[0]), 32'd1);
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] st;
    logic [3:0]  bb [3];
    logic [3:0]  exp_q [$];
    bit          seen;
    int          base;
    int          cnt_m;
    int          n;

    for (int i = 0; i < 2; i++) begin
      mmio_rd[i] = 1'b0;
      mmio_wr[i] = 1'b0;
      mmio_addr[i] = 2'd0;
    end
    bb[0] = 4'h1; bb[1] = 4'h8; bb[2] = 4'h2;

    #13;
    check("rst_rd_en", 32'(rd_en[0]), 32'd0);
    check("rst_rdata", mmio_rdata[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access(0, 1'b1, 1'b0, 2'd0, d);
    check("idle_status", d, 32'd0);
    access(0, 1'b1, 1'b0, 2'd2, d);
    check("idle_count", d, 32'd0);

    // Single press
    base = pops0;
    push(4'h4);
    wait_rd_en(0, seen);
    check("single_rd_en_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("single_rd_en_one_cycle", 32'(rd_en[0]), 32'd0);
    wait_hold(0, st);
    check("single_status_held", st, 32'h1);
    access(0, 1'b1, 1'b0, 2'd1, d);
    check("single_data", d, 32'h4);
    access(0, 1'b1, 1'b0, 2'd0, d);
    check("single_status_after", d, 32'h0);
    access(0, 1'b1, 1'b0, 2'd2, d);
    check("single_count", d, 32'd1);
    check("single_pops", 32'(pops0 - base), 32'd1);

    // Back-to-back: three queued presses, no second pop before the first data read
    access(0, 1'b0, 1'b1, 2'd2, d);
    gate = 1'b1;
    for (int i = 0; i < 3; i++) push(bb[i]);
    base = pops0;
    @(negedge clk);
    gate = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_single_pop", 32'(pops0 - base), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wait_hold(0, st);
      access(0, 1'b1, 1'b0, 2'd1, d);
      check("b2b_data", d, 32'(bb[i]));
    end
    access(0, 1'b1, 1'b0, 2'd2, d);
    check("b2b_count", d, 32'd3);
    access(0, 1'b1, 1'b0, 2'd0, d);
    check("b2b_status_final", d, 32'h0);

    // Data read with nothing held
    base = pops0;
    access(0, 1'b1, 1'b0, 2'd1, d);
    check("empty_data_read", d, 32'h0);
    repeat (3) @(negedge clk);
    check("empty_no_pop", 32'(pops0 - base), 32'd0);
    access(0, 1'b1, 1'b0, 2'd2, d);
    check("empty_count_unchanged", d, 32'd3);

    // Reset while the first entry is in flight (WAIT); it must be lost
    gate = 1'b1;
    push(4'hA);
    push(4'h5);
    push(4'h3);
    @(negedge clk);
    gate = 1'b0;
    wait_rd_en(0, seen);
    check("rstw_rd_en_seen", 32'(seen), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstw_rd_en_async", 32'(rd_en[0]), 32'd0);
    check("rstw_rdata_async", mmio_rdata[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstw_no_rd_en_at_release", 32'(rd_en[0]), 32'd0);
    @(negedge clk);
    check("rstw_rd_en_after_release", 32'(rd_en[0]), 32'd1);
    access(0, 1'b1, 1'b0, 2'd0, d);
    check("rstw_status_not_held", d, 32'h2);
    wait_hold(0, st);
    check("rstw_status_held", st, 32'h3);
    access(0, 1'b1, 1'b0, 2'd1, d);
    check("rstw_data_first", d, 32'h5);
    wait_hold(0, st);
    access(0, 1'b1, 1'b0, 2'd1, d);
    check("rstw_data_second", d, 32'h3);
    access(0, 1'b1, 1'b0, 2'd2, d);
    check("rstw_count", d, 32'd2);
    cnt_m = 2;

    // Randomized batches against the scoreboard
    for (int it = 0; it < 25; it++) begin
      n = int'($urandom_range(1, 3));
      gate = 1'b1;
      for (int j = 0; j < n; j++) begin
        logic [3:0] code;
        code = 4'($urandom);
        exp_q.push_back(code);
        push(code);
      end
      @(negedge clk);
      gate = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int j = 0; j < n; j++) begin
        wait_hold(0, st);
        cnt_m = sat(cnt_m + 1, 65535);
        check("rnd_status", st, 32'({(j < n - 1), 1'b1}));
        case ($urandom_range(0, 3))
          0: begin
            access(0, 1'b1, 1'b0, 2'd2, d);
            check("rnd_count", d, 32'(cnt_m));
          end
          1: begin
            access(0, 1'b1, 1'b1, 2'd2, d);
            check("rnd_count_rd_clr", d, 32'(cnt_m));
            cnt_m = 0;
          end
          default: ;
        endcase
        access(0, 1'b1, 1'b0, 2'd1, d);
        check("rnd_data", d, 32'(exp_q.pop_front()));
      end
    end
    access(0, 1'b1, 1'b0, 2'd0, d);
    check("rnd_status_final", d, 32'h0);
    access(0, 1'b1, 1'b0, 2'd2, d);
    check("rnd_count_final", d, 32'(cnt_m));

    // Two-bit counter: saturation, then clear coinciding with a capture
    dout1 = 4'($urandom);
    empty1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_hold(1, st);
      access(1, 1'b1, 1'b0, 2'd1, d);
      check("sat_data", d, 32'(dout1));
    end
    wait_hold(1, st);
    access(1, 1'b1, 1'b0, 2'd2, d);
    check("sat_count", d, 32'(sat(6, 3)));
    access(1, 1'b1, 1'b0, 2'd1, d);
    check("clrcap_data", d, 32'(dout1));
    check("clrcap_rd_en", 32'(rd_en[1]), 32'd1);
    access(1, 1'b0, 1'b1, 2'd2, d);
    empty1 = 1'b1;
    access(1, 1'b1, 1'b0, 2'd2, d);
    check("clrcap_count", d, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
